// File: rtl/vram_write_buffer.sv
// Posted-write FIFO between a host port and VRAM: one entry per hostWr assertion, drained into a
// single-cycle vramWr strobe whenever display fetch leaves VRAM free. Optional drop counter: VRAM_WB_DROPCNT_EN.
module vram_write_buffer #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [12:0] hostAddr,
  input  logic [7:0]  hostWrData,
  input  logic        hostWr,
  input  logic        dispBusy,
  output logic [12:0] vramAddr,
  output logic [7:0]  vramWrData,
  output logic        vramWr,
  output logic        bufEmpty,
  output logic        bufFull,
  output logic [7:0]  dropCount
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {IDLE, WRITE} state_e;

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
  } entry_t;

  entry_t                mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  state_e                state_q, state_d;
  entry_t                out_q, out_d;
  logic                  host_wr_prev_q;
  logic                  push, pop, full, accept;

  // NOTE: combinational blocks assign every output a default first so no path can infer a latch.
  always_comb begin
    push     = hostWr & ~host_wr_prev_q;
    full     = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    pop      = (count_q != '0) & ~dispBusy;
    // A pop frees the head slot on the same edge, so a full FIFO can still take the push.
    accept   = push & (~full | pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = IDLE;
    out_d    = out_q;
    if (accept) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      state_d  = WRITE;
      out_d    = mem_q[rd_ptr_q];
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      state_q        <= IDLE;
      out_q          <= '0;
      host_wr_prev_q <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      state_q        <= state_d;
      out_q          <= out_d;
      host_wr_prev_q <= hostWr;
    end
  end

  // NOTE: storage array is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= '{addr: hostAddr, data: hostWrData};
  end

  assign vramWr     = (state_q == WRITE);
  assign vramAddr   = out_q.addr;
  assign vramWrData = out_q.data;
  assign bufEmpty   = (count_q == '0);
  assign bufFull    = full;

`ifdef VRAM_WB_DROPCNT_EN
  logic       drop;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop       = push & full & ~pop;
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign dropCount = drop_cnt_q;
`else
  assign dropCount = '0;
`endif

endmodule
